// File: rtl/romulus_config_pkg.sv
// romulus_config_pkg
//   Shared configuration for the masked Romulus datapath and its bus adapters.
//   STATESHARES / KEYSHARES : share counts for the state and key paths.
//   BUSW                    : bus word width per share (must divide 128).
//   WORDS                   : beats per 128-bit block at the configured BUSW.
//   words_of / clog2_min1   : helpers so serializer and collector size their
//                             beat counters identically for any BUSW override.
//   ser_state_e             : serializer FSM states.
package romulus_config_pkg;

    localparam int STATESHARES = 2;
    localparam int KEYSHARES   = 2;
    localparam int BUSW        = 32;

    function automatic int words_of(input int busw);
        return 128 / busw;
    endfunction

    // Ceiling log2, never below 1 so a WORDS==1 counter is still a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int WORDS = words_of(BUSW);

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/share_serializer.sv
// share_serializer
//   Takes one masked 128-bit block (share-contiguous: share i at bits
//   128*i+127:128*i) and streams it as WORDS beats; beat j carries word j of
//   every share, share i in bits BUSW*i+BUSW-1:BUSW*i. Word 0 is the LS word.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   SER_IDLE | no block held, blk_ready=1, word_valid=0
//   SER_SEND | presenting word cnt of the held block, word_valid=1
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   blk_data/blk_last/blk_valid  block input, blk_ready back to upstream
//   word_data/word_valid         beat output, word_ready from downstream
//   word_eob                     beat is the final word of its block
//   word_last                    word_eob of the message's final block
module share_serializer
    import romulus_config_pkg::*;
#(
    parameter int SHARES = romulus_config_pkg::STATESHARES,
    parameter int BUSW   = romulus_config_pkg::BUSW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [128*SHARES-1:0]    blk_data,
    input  logic                     blk_last,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    output logic [BUSW*SHARES-1:0]   word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     word_eob,
    output logic                     word_last
);

    localparam int              WORDS    = words_of(BUSW);
    localparam int              CW       = clog2_min1(WORDS);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WORDS - 1);

    ser_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q,   cnt_d;
    logic [128*SHARES-1:0]      blk_q,   blk_d;
    logic                       last_q,  last_d;

    logic                       send;
    logic                       eob;
    logic                       accept;

    assign send = (state_q == SER_SEND);
    assign eob  = send && (cnt_q == LAST_CNT);

    // Ready during the final beat's handshake lets the next block load with
    // no idle cycle; this makes blk_ready combinational from word_ready.
    assign blk_ready = !rst && (!send || (eob && word_ready));
    assign accept    = blk_valid && blk_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        last_d  = last_q;
        unique case (state_q)
            SER_IDLE: begin
                if (accept) begin
                    state_d = SER_SEND;
                    cnt_d   = '0;
                    blk_d   = blk_data;
                    last_d  = blk_last;
                end
            end
            SER_SEND: begin
                if (word_ready) begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (accept) begin
                        cnt_d  = '0;
                        blk_d  = blk_data;
                        last_d = blk_last;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    // Per-share word select; the held block is cleared on reset, so the bus
    // reads zero until the first block is captured.
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        logic [BUSW-1:0] beat;
        always_comb begin
            beat = '0;
            for (int w = 0; w < WORDS; w++) begin
                if (cnt_q == CW'(w)) beat = blk_q[128*i + BUSW*w +: BUSW];
            end
        end
        assign word_data[BUSW*i +: BUSW] = beat;
    end

    assign word_valid = send;
    assign word_eob   = eob;
    assign word_last  = eob && last_q;

endmodule

// File: doc/share_serializer.md
Name: share_serializer

Overview:
- Transmit-side counterpart of the share-interleaved bus format.
- Accepts one full masked 128-bit block in share-contiguous layout (share i occupies bits 128*i+127:128*i) over a valid/ready handshake.
- Streams the block out as 128/BUSW bus beats. Each beat carries word j of every share, interleaved share-by-share.
- Sits between the TBC/state datapath and the BUSW-wide output interface. Drives the bus-facing data port of the protected core.

Parameters:
- SHARES, STATESHARES (from romulus_config_pkg), number of shares per block.
- BUSW, BUSW (from romulus_config_pkg), bus word width per share; must divide 128.
- WORDS, 128/BUSW (derived, localparam), beats per block.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- blk_data  input  128*SHARES  block to send, share-contiguous layout.
- blk_last  input  1  block is the final block of the message.
- blk_valid  input  1  blk_data/blk_last valid.
- blk_ready  output  1  serializer can accept a block this cycle.
- word_data  output  BUSW*SHARES  current beat, interleaved layout.
- word_valid  output  1  word_data valid.
- word_ready  input  1  downstream accepts the beat.
- word_eob  output  1  current beat is the last beat (j=WORDS-1) of its block.
- word_last  output  1  word_eob AND the captured blk_last.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0, shift register=0, captured last flag=0.
  - word_valid=0, word_data=0, word_eob=0, word_last=0.
  - blk_ready is forced 0 while rst is high.
- Reset mid-block: the block in flight is discarded. No further beats are emitted. The serializer is in IDLE the cycle after rst deasserts.
- States:
  - IDLE: word_valid=0, blk_ready=1.
  - SEND: word_valid=1.
- Accept:
  - Block acceptance is blk_valid & blk_ready.
  - On acceptance, capture blk_data into the shift register, capture blk_last, set cnt=0, go to SEND.
  - First beat is valid the next cycle, so block-to-first-beat latency is 1 cycle.
- Beat mapping:
  - word_data[BUSW*i+BUSW-1 : BUSW*i] = share i, word cnt.
  - Equivalently blk_data[128*i+BUSW*cnt+BUSW-1 : 128*i+BUSW*cnt] of the captured block.
  - Word 0 is the least-significant word of each share.
- Hold: word_data, word_eob and word_last stay stable while word_valid=1 and word_ready=0. No beat is ever dropped or repeated.
- Advance: word_valid & word_ready with cnt<WORDS-1 increments cnt (shift-register implementation is allowed, but the output must be identical).
- Last beat (word_valid & word_ready with cnt==WORDS-1):
  - If blk_valid=1 in the same cycle, the new block is captured, cnt=0 and the state stays SEND. There is no bubble, so throughput is one beat per cycle across blocks.
  - Otherwise go to IDLE.
- blk_ready = (state==IDLE) OR (state==SEND AND cnt==WORDS-1 AND word_ready), gated by !rst. This path is combinational from word_ready.
- word_eob = (state==SEND AND cnt==WORDS-1).
- word_last = word_eob AND captured last flag.
- blk_valid while not ready: ignored. The upstream must hold its data.
- cnt width is clog2(WORDS), minimum 1. cnt never exceeds WORDS-1.
- WORDS==1 (BUSW=128) is legal: every beat is both first and last.

Decomposition:
- romulus_config_pkg.v already supplies STATESHARES and BUSW. The WORDS localparam and a clog2 helper function belong there, shared with the receiving collector.
- No sub-module. The beat mux is a generate loop over shares inside this block. A key variant is instantiated with SHARES=KEYSHARES.

Test Plan (BUSW=32, SHARES=2, WORDS=4; share0=128'h00112233_44556677_8899AABB_CCDDEEFF, share1=128'hFFEEDDCC_BBAA9988_77665544_33221100):
1. Single block, word_ready=1 throughout:
   - Required beats: 64'h33221100_CCDDEEFF, 64'h77665544_8899AABB, 64'hBBAA9988_44556677, 64'hFFEEDDCC_00112233.
   - word_eob only on beat 4; first beat one cycle after acceptance; blk_ready low during beats 1-3.
2. Same block with blk_last=1 and word_ready toggling 1,0,0,1,... -> each beat is held unchanged while stalled; exactly 4 beats are transferred; word_last=1 only on beat 4.
3. Two blocks offered back-to-back with word_ready=1 -> blk_ready=1 on the beat-4 cycle; 8 consecutive valid beats with no gap; second block's beat 1 appears the cycle after the first block's beat 4.
4. rst pulsed for one cycle after beat 2 of a block -> word_valid=0 and word_data=0 the next cycle; remaining beats are never emitted; a new block afterwards serializes correctly from word 0.
5. blk_valid held high during beats 1-3 -> that block is not captured until the beat-4 handshake; no corruption of the in-flight block.
6. Parameter sweep BUSW=128 (WORDS=1) and SHARES=3 -> the beat equals the share concatenation; word_eob=1 on every beat; back-to-back blocks sustain 1 block/cycle.
